// File: rtl/ocm_rr_atomic_if.sv
// Request/response bus between the cores and the shared on-chip memory.
// Per-core fields are packed flat, core c occupying slice c of each vector.
interface ocm_rr_atomic_if #(
  parameter int N_CORES   = 2,
  parameter int ADDR_BITS = 12
);
  logic [N_CORES-1:0]           i_req;
  logic [3*N_CORES-1:0]         i_op;
  logic [ADDR_BITS*N_CORES-1:0] i_addr;
  logic [32*N_CORES-1:0]        i_wdata;
  logic [4*N_CORES-1:0]         i_wstrb;
  logic [N_CORES-1:0]           o_gnt;
  logic [N_CORES-1:0]           o_resp_valid;
  logic [31:0]                  o_rdata;
  logic                         o_busy;

  modport master (
    output i_req, i_op, i_addr, i_wdata, i_wstrb,
    input  o_gnt, o_resp_valid, o_rdata, o_busy
  );

  modport slave (
    input  i_req, i_op, i_addr, i_wdata, i_wstrb,
    output o_gnt, o_resp_valid, o_rdata, o_busy
  );
endinterface

// File: rtl/ocm_rr_atomic.sv
// Shared uncached word memory with round-robin arbitration, LR/SC reservations
// and single-grant AMO read-modify-write; port B is a read-only debug view.
module ocm_rr_atomic #(
  parameter int N_CORES   = 2,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  ocm_rr_atomic_if.slave       bus,
  input  logic [ADDR_BITS-1:0] i_tb_addr,
  output logic [31:0]          o_tb_data
);
  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [2:0] {
    OP_LOAD, OP_STORE, OP_LR, OP_SC, OP_AMOSWAP, OP_AMOADD, OP_AMOAND, OP_AMOOR
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WB, ST_RESP} state_e;

  logic                 core_req   [N_CORES];
  logic [2:0]           core_op    [N_CORES];
  logic [ADDR_BITS-1:0] core_addr  [N_CORES];
  logic [31:0]          core_wdata [N_CORES];
  logic [3:0]           core_wstrb [N_CORES];
  logic                 res_valid  [N_CORES];
  logic [ADDR_BITS-1:0] res_addr   [N_CORES];

  state_e               state_reg;
  logic [PW-1:0]        ptr_reg;
  logic [PW-1:0]        lat_core_reg;
  op_e                  lat_op_reg;
  logic [ADDR_BITS-1:0] lat_addr_reg;
  logic [31:0]          lat_wdata_reg;
  logic [3:0]           lat_wstrb_reg;
  logic [31:0]          old_reg;
  logic [N_CORES-1:0]   gnt_reg;
  logic [N_CORES-1:0]   resp_reg;
  logic [31:0]          rdata_reg;
  logic [31:0]          ram_q_reg;
  logic [31:0]          tb_q_reg;

  logic [31:0]          mem [2**ADDR_BITS];

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [N_CORES-1:0]   win_onehot;
  logic                 sc_ok;
  logic [31:0]          amo_new;
  logic                 mem_we;
  logic [3:0]           mem_be;
  logic [31:0]          mem_wdata;
  logic [ADDR_BITS-1:0] ram_raddr;

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_core
      logic                 res_v_reg;
      logic [ADDR_BITS-1:0] res_a_reg;

      assign core_req[gi]   = bus.i_req[gi];
      assign core_op[gi]    = bus.i_op[gi*3 +: 3];
      assign core_addr[gi]  = bus.i_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign core_wdata[gi] = bus.i_wdata[gi*32 +: 32];
      assign core_wstrb[gi] = bus.i_wstrb[gi*4 +: 4];
      assign res_valid[gi]  = res_v_reg;
      assign res_addr[gi]   = res_a_reg;

      // Own LR/SC in RD take precedence; any committed write to the
      // reserved word kills the reservation of every core.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_v_reg <= 1'b0;
          res_a_reg <= '0;
        end else if (state_reg == ST_RD && lat_core_reg == PW'(gi) && lat_op_reg == OP_LR) begin
          res_v_reg <= 1'b1;
          res_a_reg <= lat_addr_reg;
        end else if (state_reg == ST_RD && lat_core_reg == PW'(gi) && lat_op_reg == OP_SC) begin
          res_v_reg <= 1'b0;
        end else if (mem_we && res_a_reg == lat_addr_reg) begin
          res_v_reg <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    int            cand_int;
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      cand_int = (int'(ptr_reg) + k) % N_CORES;
      cand     = PW'(cand_int);
      if (!win_found && core_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = {{(N_CORES-1){1'b0}}, 1'b1} << win_idx;
  assign sc_ok      = res_valid[lat_core_reg] && (res_addr[lat_core_reg] == lat_addr_reg);

  always_comb begin
    amo_new = lat_wdata_reg;
    case (lat_op_reg)
      OP_AMOADD: amo_new = old_reg + lat_wdata_reg;
      OP_AMOAND: amo_new = old_reg & lat_wdata_reg;
      OP_AMOOR:  amo_new = old_reg | lat_wdata_reg;
      default:   amo_new = lat_wdata_reg;
    endcase
  end

  // WB is only entered for AMOs and successful SCs, so it always writes.
  assign mem_we    = !rst && ((state_reg == ST_RD && lat_op_reg == OP_STORE) || state_reg == ST_WB);
  assign mem_be    = (state_reg == ST_RD) ? lat_wstrb_reg : 4'hF;
  assign mem_wdata = (state_reg == ST_RD) ? lat_wdata_reg : amo_new;
  // Read is launched on the latch edge so the word is ready during RD.
  assign ram_raddr = (state_reg == ST_IDLE) ? core_addr[win_idx] : lat_addr_reg;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[lat_addr_reg][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
    ram_q_reg <= mem[ram_raddr];
  end

  always_ff @(posedge clk) begin
    tb_q_reg <= mem[i_tb_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= PW'(N_CORES - 1);
      lat_core_reg  <= '0;
      lat_op_reg    <= OP_LOAD;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      lat_wstrb_reg <= '0;
      old_reg       <= '0;
      gnt_reg       <= '0;
      resp_reg      <= '0;
      rdata_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          resp_reg  <= '0;
          rdata_reg <= '0;
          gnt_reg   <= '0;
          if (win_found) begin
            ptr_reg       <= win_idx;
            lat_core_reg  <= win_idx;
            lat_op_reg    <= op_e'(core_op[win_idx]);
            lat_addr_reg  <= core_addr[win_idx];
            lat_wdata_reg <= core_wdata[win_idx];
            lat_wstrb_reg <= core_wstrb[win_idx];
            gnt_reg       <= win_onehot;
            state_reg     <= ST_RD;
          end
        end
        ST_RD: begin
          case (lat_op_reg)
            OP_LOAD, OP_LR: begin
              rdata_reg <= ram_q_reg;
              resp_reg  <= gnt_reg;
              state_reg <= ST_RESP;
            end
            OP_STORE: begin
              rdata_reg <= '0;
              resp_reg  <= gnt_reg;
              state_reg <= ST_RESP;
            end
            OP_SC: begin
              if (sc_ok) begin
                state_reg <= ST_WB;
              end else begin
                rdata_reg <= 32'd1;
                resp_reg  <= gnt_reg;
                state_reg <= ST_RESP;
              end
            end
            default: begin
              old_reg   <= ram_q_reg;
              state_reg <= ST_WB;
            end
          endcase
        end
        ST_WB: begin
          rdata_reg <= (lat_op_reg == OP_SC) ? 32'd0 : old_reg;
          resp_reg  <= gnt_reg;
          state_reg <= ST_RESP;
        end
        default: begin
          resp_reg  <= '0;
          gnt_reg   <= '0;
          rdata_reg <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt        = gnt_reg;
  assign bus.o_resp_valid = resp_reg;
  assign bus.o_rdata      = rdata_reg;
  assign bus.o_busy       = (state_reg != ST_IDLE);
  assign o_tb_data        = tb_q_reg;
endmodule

// File: tb/tb_ocm_rr_atomic.sv
// Bench for ocm_rr_atomic: directed vector table, arbitration and reset-abort
// sequences, then a spinlock and a random mix checked against a word-level model.
module tb_ocm_rr_atomic;
  localparam int N  = 2;
  localparam int AB = 12;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_LR = 3'd2, OP_SC = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4, OP_ADD = 3'd5, OP_AND = 3'd6, OP_OR = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] tb_addr;
  logic [31:0]   tb_data;

  always #5 clk = ~clk;

  ocm_rr_atomic_if #(.N_CORES(N), .ADDR_BITS(AB)) bus ();

  ocm_rr_atomic #(.N_CORES(N), .ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .i_tb_addr (tb_addr),
    .o_tb_data (tb_data)
  );

  typedef struct {
    int          core;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  // Reference model: plain word memory plus one {valid, addr} per core.
  logic [31:0] mm [int];
  bit          rv [N];
  int          ra [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add_vec(input int c, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         input logic [31:0] exp, input int lat);
    vec_t v;
    v.core = c; v.op = op; v.addr = a; v.wdata = wd; v.strb = st; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] model_apply(input int c, input logic [2:0] op, input int a,
                                              input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] old;
    logic [31:0] nw;
    old = mm.exists(a) ? mm[a] : 32'h0;
    case (op)
      OP_LOAD: return old;
      OP_LR: begin
        rv[c] = 1'b1; ra[c] = a;
        return old;
      end
      OP_STORE: begin
        nw = old;
        for (int b = 0; b < 4; b++) if (st[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
        mm[a] = nw;
        for (int k = 0; k < N; k++) if (ra[k] == a) rv[k] = 1'b0;
        return 32'h0;
      end
      OP_SC: begin
        if (rv[c] && ra[c] == a) begin
          rv[c] = 1'b0;
          mm[a] = wd;
          for (int k = 0; k < N; k++) if (ra[k] == a) rv[k] = 1'b0;
          return 32'h0;
        end
        rv[c] = 1'b0;
        return 32'h1;
      end
      default: begin
        case (op)
          OP_SWAP: nw = wd;
          OP_ADD:  nw = old + wd;
          OP_AND:  nw = old & wd;
          default: nw = old | wd;
        endcase
        mm[a] = nw;
        for (int k = 0; k < N; k++) if (ra[k] == a) rv[k] = 1'b0;
        return old;
      end
    endcase
  endfunction

  task automatic drive(input int c, input logic [2:0] op, input logic [AB-1:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    bus.i_req[c]          = 1'b1;
    bus.i_op[c*3 +: 3]    = op;
    bus.i_addr[c*AB +: AB] = a;
    bus.i_wdata[c*32 +: 32] = wd;
    bus.i_wstrb[c*4 +: 4] = st;
  endtask

  // Latency = negedges from request to pulse, i.e. pulse cycle relative to latch cycle.
  task automatic do_txn(input int c, input logic [2:0] op, input logic [AB-1:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output int lat, output logic [N-1:0] g);
    @(negedge clk);
    drive(c, op, a, wd, st);
    rd = 'x; lat = 0; g = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.o_resp_valid[c]) begin
        rd = bus.o_rdata; lat = k; g = bus.o_gnt;
        break;
      end
    end
    bus.i_req[c] = 1'b0;
  endtask

  task automatic tb_read(input logic [AB-1:0] a, output logic [31:0] d);
    @(negedge clk);
    tb_addr = a;
    @(negedge clk);
    d = tb_data;
  endtask

  task automatic two_req(output int first, output int second);
    int  order [2];
    int  n;
    bit  pend [N];
    @(negedge clk);
    drive(0, OP_LOAD, 12'h010, 32'h0, 4'hF);
    drive(1, OP_LOAD, 12'h020, 32'h0, 4'hF);
    pend[0] = 1'b1; pend[1] = 1'b1; n = 0; order[0] = -1; order[1] = -1;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (pend[c] && bus.o_resp_valid[c]) begin
          order[n] = c; n++; pend[c] = 1'b0; bus.i_req[c] = 1'b0;
        end
      end
    end
    bus.i_req = '0;
    first = order[0]; second = order[1];
  endtask

  // Both cores issue concurrently; every pulse is checked against the model
  // in completion order. mode 0: random mix, mode 1: spinlock on 0x040.
  task automatic run_phase(input int mode, input int n_ops);
    bit          act [N];
    bit          hold [N];
    int          acq [N];
    logic [2:0]  pop [N];
    logic [AB-1:0] pad [N];
    logic [31:0] pwd [N];
    logic [3:0]  pst [N];
    logic [31:0] exp;
    int          issued = 0;
    int          done = 0;
    int          cyc = 0;
    for (int c = 0; c < N; c++) begin act[c] = 0; hold[c] = 0; acq[c] = 0; end
    while (done < n_ops) begin
      @(negedge clk);
      cyc++;
      if (cyc > n_ops * 12) begin
        chk("phase_timeout", 32'(done), 32'(n_ops));
        break;
      end
      chk("gnt_onehot", 32'($countones(bus.o_gnt) <= 1), 32'd1);
      for (int c = 0; c < N; c++) begin
        if (act[c] && bus.o_resp_valid[c]) begin
          exp = model_apply(c, pop[c], int'(pad[c]), pwd[c], pst[c]);
          chk(mode == 1 ? "spin_rdata" : "rand_rdata", bus.o_rdata, exp);
          if (mode == 1) begin
            if (pop[c] == OP_SWAP && exp == 32'h0) begin hold[c] = 1; acq[c]++; end
            if (pop[c] == OP_STORE) hold[c] = 0;
          end
          act[c] = 0; bus.i_req[c] = 1'b0; done++;
        end
      end
      for (int c = 0; c < N; c++) begin
        if (!act[c] && issued < n_ops && $urandom_range(0, 3) != 0) begin
          if (mode == 1) begin
            pop[c] = hold[c] ? OP_STORE : OP_SWAP;
            pad[c] = 12'h040; pwd[c] = hold[c] ? 32'h0 : 32'h1; pst[c] = 4'hF;
          end else begin
            pop[c] = 3'($urandom_range(0, 7));
            pad[c] = 12'h100 + 12'($urandom_range(0, 3));
            pwd[c] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 9));
            pst[c] = 4'($urandom_range(0, 15));
          end
          drive(c, pop[c], pad[c], pwd[c], pst[c]);
          act[c] = 1; issued++;
        end
      end
    end
    bus.i_req = '0;
    repeat (3) @(negedge clk);
    if (mode == 1) begin
      chk("spin_core0_acquired", 32'(acq[0] > 0), 32'd1);
      chk("spin_core1_acquired", 32'(acq[1] > 0), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [N-1:0] g;
    int          f, s;

    bus.i_req = '0; bus.i_op = '0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_wstrb = '0;
    tb_addr = '0;
    rst = 1'b1;
    for (int c = 0; c < N; c++) begin rv[c] = 0; ra[c] = -1; end

    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(bus.o_gnt), 32'h0);
    chk("reset_resp", 32'(bus.o_resp_valid), 32'h0);
    chk("reset_rdata", bus.o_rdata, 32'h0);
    chk("reset_busy", 32'(bus.o_busy), 32'h0);
    rst = 1'b0;

    // Round robin from the reset pointer (N-1): core0 wins, then core1, twice over.
    two_req(f, s);
    chk("rr1_first", 32'(f), 32'd0);
    chk("rr1_second", 32'(s), 32'd1);
    two_req(f, s);
    chk("rr2_first", 32'(f), 32'd0);
    chk("rr2_second", 32'(s), 32'd1);

    add_vec(0, OP_STORE, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 2);
    add_vec(0, OP_LOAD,  12'h010, 32'h0, 4'hF, 32'hDEADBEEF, 2);
    add_vec(1, OP_STORE, 12'h010, 32'h11223344, 4'h5, 32'h0, 2);
    add_vec(1, OP_LOAD,  12'h010, 32'h0, 4'hF, 32'hDE22BE44, 2);
    add_vec(0, OP_STORE, 12'h020, 32'd5, 4'hF, 32'h0, 2);
    add_vec(0, OP_ADD,   12'h020, 32'd3, 4'hF, 32'd5, 3);
    add_vec(1, OP_LOAD,  12'h020, 32'h0, 4'hF, 32'd8, 2);
    add_vec(0, OP_STORE, 12'h021, 32'hFFFFFFFF, 4'hF, 32'h0, 2);
    add_vec(1, OP_ADD,   12'h021, 32'd1, 4'hF, 32'hFFFFFFFF, 3);
    add_vec(0, OP_LOAD,  12'h021, 32'h0, 4'hF, 32'h0, 2);
    add_vec(0, OP_STORE, 12'h030, 32'hA5, 4'hF, 32'h0, 2);
    add_vec(0, OP_LR,    12'h030, 32'h0, 4'hF, 32'hA5, 2);
    add_vec(1, OP_STORE, 12'h030, 32'h77, 4'hF, 32'h0, 2);
    add_vec(0, OP_SC,    12'h030, 32'h99, 4'hF, 32'h1, 2);
    add_vec(1, OP_LOAD,  12'h030, 32'h0, 4'hF, 32'h77, 2);
    add_vec(0, OP_LR,    12'h030, 32'h0, 4'hF, 32'h77, 2);
    add_vec(0, OP_SC,    12'h030, 32'h99, 4'hF, 32'h0, 3);
    add_vec(1, OP_LOAD,  12'h030, 32'h0, 4'hF, 32'h99, 2);
    add_vec(0, OP_SC,    12'h030, 32'h55, 4'hF, 32'h1, 2);
    add_vec(1, OP_LOAD,  12'h030, 32'h0, 4'hF, 32'h99, 2);
    add_vec(0, OP_STORE, 12'h031, 32'h0, 4'hF, 32'h0, 2);
    add_vec(1, OP_LR,    12'h031, 32'h0, 4'hF, 32'h0, 2);
    add_vec(0, OP_STORE, 12'h031, 32'hFF, 4'h1, 32'h0, 2);
    add_vec(1, OP_SC,    12'h031, 32'h1234, 4'hF, 32'h1, 2);
    add_vec(1, OP_LOAD,  12'h031, 32'h0, 4'hF, 32'hFF, 2);
    add_vec(0, OP_STORE, 12'h050, 32'hF0F0, 4'hF, 32'h0, 2);
    add_vec(1, OP_AND,   12'h050, 32'hFF00, 4'hF, 32'hF0F0, 3);
    add_vec(1, OP_OR,    12'h050, 32'h000F, 4'hF, 32'hF000, 3);
    add_vec(0, OP_SWAP,  12'h050, 32'h1234, 4'hF, 32'hF00F, 3);
    add_vec(0, OP_LOAD,  12'h050, 32'h0, 4'hF, 32'h1234, 2);
    add_vec(0, OP_STORE, 12'h060, 32'h42, 4'hF, 32'h0, 2);
    add_vec(0, OP_LR,    12'h060, 32'h0, 4'hF, 32'h42, 2);
    add_vec(1, OP_SC,    12'h060, 32'h7, 4'hF, 32'h1, 2);
    add_vec(0, OP_SC,    12'h060, 32'h8, 4'hF, 32'h0, 3);
    add_vec(0, OP_LR,    12'h060, 32'h0, 4'hF, 32'h8, 2);
    add_vec(1, OP_STORE, 12'h060, 32'hEE, 4'h0, 32'h0, 2);
    add_vec(0, OP_SC,    12'h060, 32'h9, 4'hF, 32'h1, 2);
    add_vec(1, OP_LOAD,  12'h060, 32'h0, 4'hF, 32'h8, 2);

    foreach (vecs[i]) begin
      do_txn(vecs[i].core, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, lat, g);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_gnt", i), 32'(g), 32'(1 << vecs[i].core));
    end

    tb_read(12'h050, rd);
    chk("portb_read", rd, 32'h1234);

    // Reset landing on the WB edge of an AMOSWAP must abort it cleanly.
    do_txn(0, OP_STORE, 12'h070, 32'hAAAA, 4'hF, rd, lat, g);
    do_txn(1, OP_LR, 12'h070, 32'h0, 4'hF, rd, lat, g);
    chk("abort_lr", rd, 32'hAAAA);
    @(negedge clk);
    drive(0, OP_SWAP, 12'h070, 32'hBBBB, 4'hF);
    @(negedge clk);
    chk("abort_busy_rd", 32'(bus.o_busy), 32'h1);
    chk("abort_gnt_rd", 32'(bus.o_gnt), 32'h1);
    @(negedge clk);
    chk("abort_no_early_resp", 32'(bus.o_resp_valid), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_gnt", 32'(bus.o_gnt), 32'h0);
    chk("abort_resp", 32'(bus.o_resp_valid), 32'h0);
    chk("abort_busy", 32'(bus.o_busy), 32'h0);
    rst = 1'b0;
    bus.i_req = '0;
    @(negedge clk);
    chk("abort_no_late_resp", 32'(bus.o_resp_valid), 32'h0);
    tb_read(12'h070, rd);
    chk("abort_mem_unchanged", rd, 32'hAAAA);
    do_txn(1, OP_SC, 12'h070, 32'hCCCC, 4'hF, rd, lat, g);
    chk("abort_res_cleared", rd, 32'h1);
    do_txn(1, OP_LOAD, 12'h070, 32'h0, 4'hF, rd, lat, g);
    chk("abort_load", rd, 32'hAAAA);

    // Model-checked phases start from known contents.
    for (int a = 0; a < 4; a++) begin
      do_txn(a % 2, OP_STORE, 12'h100 + 12'(a), 32'h1000 * 32'(a + 1), 4'hF, rd, lat, g);
      chk("init_store", rd, model_apply(a % 2, OP_STORE, 32'h100 + a, 32'h1000 * 32'(a + 1), 4'hF));
    end
    do_txn(0, OP_STORE, 12'h040, 32'h0, 4'hF, rd, lat, g);
    chk("init_lock", rd, model_apply(0, OP_STORE, 32'h40, 32'h0, 4'hF));

    run_phase(1, 1000);
    tb_read(12'h040, rd);
    chk("spin_final_lock", rd, mm[32'h40]);

    run_phase(0, 600);
    for (int a = 0; a < 4; a++) begin
      tb_read(12'h100 + 12'(a), rd);
      chk($sformatf("rand_final_mem%0d", a), rd, mm[32'h100 + a]);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
